// File: rtl/lcd_pkg.sv
// Shared types, init table, command codes, timing defaults and the delay helper
// for the character-LCD nibble writer.
package lcd_pkg;

    localparam int unsigned CNT_W = 20;

    // Default timing in 50 MHz clock cycles
    localparam int unsigned T_POWERUP_DEF = 750000;
    localparam int unsigned T_INIT1_DEF   = 205000;
    localparam int unsigned T_INIT2_DEF   = 5000;
    localparam int unsigned T_CMD_DEF     = 2000;
    localparam int unsigned T_CLEAR_DEF   = 82000;
    localparam int unsigned T_SETUP_DEF   = 2;
    localparam int unsigned T_EHIGH_DEF   = 12;
    localparam int unsigned T_GAP_DEF     = 50;

    typedef enum logic [2:0] {
        ST_PWR_WAIT,
        ST_INIT_SEND,
        ST_INIT_WAIT,
        ST_IDLE,
        ST_SETUP,
        ST_E_HIGH,
        ST_GAP,
        ST_POST
    } lcd_state_e;

    // 4-bit mode power-on sequence, sent with rs=0
    localparam logic [3:0] INIT_NIBBLES [0:3] = '{4'h3, 4'h3, 4'h3, 4'h2};

    // Commands that need the long post-wait
    localparam logic [7:0] CMD_CLEAR     = 8'h01;
    localparam logic [7:0] CMD_HOME      = 8'h02;
    localparam logic [7:0] CMD_HOME_ALT  = 8'h03;

    // Counter load value for an N-cycle wait; N=0 behaves as a 1-cycle wait
    function automatic logic [CNT_W-1:0] dly(input int unsigned n);
        return (n == 0) ? '0 : CNT_W'(n - 1);
    endfunction

    function automatic logic is_slow_cmd(input logic rs, input logic [7:0] data);
        return !rs && (data == CMD_CLEAR || data == CMD_HOME || data == CMD_HOME_ALT);
    endfunction

endpackage

// File: rtl/lcd_delay_timer.sv
// Shared down-counter for all LCD waits.
//  clk, rst     : clock, asynchronous active-high reset (reloads RESET_VAL)
//  load         : load load_val this cycle
//  load_val     : N-1 for an N-cycle wait
//  done_c       : counter is at zero (combinational)
module lcd_delay_timer
    import lcd_pkg::*;
#(
    parameter logic [CNT_W-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             done_c
);

    logic [CNT_W-1:0] cnt_q;

    // Load wins over counting; holds at zero until reloaded
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= RESET_VAL;
        end else if (load) begin
            cnt_q <= load_val;
        end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - CNT_W'(1);
        end
    end

    assign done_c = (cnt_q == '0);

endmodule

// File: rtl/lcd_nibble_writer.sv
// Byte-at-a-time writer for the HD44780-style character LCD in 4-bit mode.
// Runs the power-on init, then sends each accepted byte as two timed nibbles.
//  clk, rst            : clock, asynchronous active-high reset
//  req_valid/req_ready : byte handshake; req_rs selects command(0)/data(1)
//  req_data            : byte to write
//  init_done           : init sequence finished, sticky until reset
//  sf_e, lcd_rw        : tied off (flash disabled, write-only)
//  lcd_e/lcd_rs/lcd_db : LCD strobe, register select, DB7..DB4
module lcd_nibble_writer
    import lcd_pkg::*;
#(
    parameter int unsigned T_POWERUP = T_POWERUP_DEF,
    parameter int unsigned T_INIT1   = T_INIT1_DEF,
    parameter int unsigned T_INIT2   = T_INIT2_DEF,
    parameter int unsigned T_CMD     = T_CMD_DEF,
    parameter int unsigned T_CLEAR   = T_CLEAR_DEF,
    parameter int unsigned T_SETUP   = T_SETUP_DEF,
    parameter int unsigned T_EHIGH   = T_EHIGH_DEF,
    parameter int unsigned T_GAP     = T_GAP_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req_valid,
    input  logic       req_rs,
    input  logic [7:0] req_data,
    output logic       req_ready,
    output logic       init_done,
    output logic       sf_e,
    output logic       lcd_e,
    output logic       lcd_rs,
    output logic       lcd_rw,
    output logic [3:0] lcd_db
);

    lcd_state_e       state_q, state_d;
    logic [1:0]       idx_q, idx_d;
    logic             second_q, second_d;
    logic             rs_q, rs_d;
    logic [7:0]       data_q, data_d;
    logic             init_done_d, req_ready_d, lcd_e_d, lcd_rs_d;
    logic [3:0]       lcd_db_d;
    logic             load;
    logic [CNT_W-1:0] load_val;
    logic             done_c;

    assign sf_e   = 1'b1;
    assign lcd_rw = 1'b0;

    // Reset value covers the power-up wait so no load is needed on entry
    lcd_delay_timer #(
        .RESET_VAL (dly(T_POWERUP))
    ) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (load),
        .load_val (load_val),
        .done_c   (done_c)
    );

    // State, capture and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_PWR_WAIT;
            idx_q     <= '0;
            second_q  <= 1'b0;
            rs_q      <= 1'b0;
            data_q    <= '0;
            init_done <= 1'b0;
            req_ready <= 1'b0;
            lcd_e     <= 1'b0;
            lcd_rs    <= 1'b0;
            lcd_db    <= '0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            second_q  <= second_d;
            rs_q      <= rs_d;
            data_q    <= data_d;
            init_done <= init_done_d;
            req_ready <= req_ready_d;
            lcd_e     <= lcd_e_d;
            lcd_rs    <= lcd_rs_d;
            lcd_db    <= lcd_db_d;
        end
    end

    // Next state; every transition into a timed state loads the shared timer
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        second_d    = second_q;
        rs_d        = rs_q;
        data_d      = data_q;
        init_done_d = init_done;
        load        = 1'b0;
        load_val    = '0;

        case (state_q)
            ST_PWR_WAIT: begin
                if (done_c) begin
                    state_d  = ST_INIT_SEND;
                    load     = 1'b1;
                    load_val = dly(T_SETUP);
                end
            end
            ST_INIT_SEND, ST_SETUP: begin
                if (done_c) begin
                    state_d  = ST_E_HIGH;
                    load     = 1'b1;
                    load_val = dly(T_EHIGH);
                end
            end
            ST_E_HIGH: begin
                if (done_c) begin
                    load = 1'b1;
                    if (!init_done) begin
                        state_d = ST_INIT_WAIT;
                        case (idx_q)
                            2'd0:    load_val = dly(T_INIT1);
                            2'd1:    load_val = dly(T_INIT2);
                            default: load_val = dly(T_CMD);
                        endcase
                    end else if (!second_q) begin
                        state_d  = ST_GAP;
                        load_val = dly(T_GAP);
                    end else begin
                        state_d  = ST_POST;
                        load_val = is_slow_cmd(rs_q, data_q) ? dly(T_CLEAR) : dly(T_CMD);
                    end
                end
            end
            ST_INIT_WAIT: begin
                if (done_c) begin
                    if (idx_q == 2'd3) begin
                        state_d     = ST_IDLE;
                        init_done_d = 1'b1;
                    end else begin
                        idx_d    = idx_q + 2'd1;
                        state_d  = ST_INIT_SEND;
                        load     = 1'b1;
                        load_val = dly(T_SETUP);
                    end
                end
            end
            ST_IDLE: begin
                if (req_valid && req_ready) begin
                    rs_d     = req_rs;
                    data_d   = req_data;
                    second_d = 1'b0;
                    state_d  = ST_SETUP;
                    load     = 1'b1;
                    load_val = dly(T_SETUP);
                end
            end
            ST_GAP: begin
                if (done_c) begin
                    second_d = 1'b1;
                    state_d  = ST_SETUP;
                    load     = 1'b1;
                    load_val = dly(T_SETUP);
                end
            end
            ST_POST: begin
                if (done_c) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_PWR_WAIT;
        endcase
    end

    // Outputs are decoded from the next state so the registers line up with the state
    always_comb begin
        lcd_e_d     = (state_d == ST_E_HIGH);
        req_ready_d = (state_d == ST_IDLE) && init_done_d;
        lcd_rs_d    = lcd_rs;
        lcd_db_d    = lcd_db;
        if (state_d == ST_INIT_SEND) begin
            lcd_rs_d = 1'b0;
            lcd_db_d = INIT_NIBBLES[idx_d];
        end else if (state_d == ST_SETUP) begin
            lcd_rs_d = rs_d;
            lcd_db_d = second_d ? data_d[3:0] : data_d[7:4];
        end
    end

endmodule

// File: tb/tb_lcd_nibble_writer.sv
// Directed bench for lcd_nibble_writer with shortened timing.
module tb_lcd_nibble_writer;

    localparam int T_POWERUP = 100;
    localparam int T_INIT1   = 40;
    localparam int T_INIT2   = 20;
    localparam int T_CMD     = 10;
    localparam int T_CLEAR   = 30;
    localparam int T_SETUP   = 2;
    localparam int T_EHIGH   = 4;
    localparam int T_GAP     = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       req_valid = 1'b0;
    logic       req_rs = 1'b0;
    logic [7:0] req_data = '0;
    logic       req_ready, init_done, sf_e, lcd_e, lcd_rs, lcd_rw;
    logic [3:0] lcd_db;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    typedef struct {
        logic [3:0] db;
        logic       rs;
        int         rise;
    } pulse_t;
    pulse_t pq[$];

    lcd_nibble_writer #(
        .T_POWERUP (T_POWERUP), .T_INIT1 (T_INIT1), .T_INIT2 (T_INIT2),
        .T_CMD     (T_CMD),     .T_CLEAR (T_CLEAR), .T_SETUP (T_SETUP),
        .T_EHIGH   (T_EHIGH),   .T_GAP   (T_GAP)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_rs    (req_rs),
        .req_data  (req_data),
        .req_ready (req_ready),
        .init_done (init_done),
        .sf_e      (sf_e),
        .lcd_e     (lcd_e),
        .lcd_rs    (lcd_rs),
        .lcd_rw    (lcd_rw),
        .lcd_db    (lcd_db)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // E-pulse monitor: width, bus stability while high, lcd_rw low
    logic       e_prev = 1'b0;
    int         e_width = 0;
    int         rise_cyc = 0;
    logic [3:0] db_rise = '0;
    logic       rs_rise = 1'b0;
    logic       unstable = 1'b0;
    always @(negedge clk) begin
        if (rst) begin
            e_prev  = 1'b0;
            e_width = 0;
        end else begin
            if (lcd_rw !== 1'b0) unstable = 1'b1;
            if (lcd_e === 1'b1 && !e_prev) begin
                db_rise  = lcd_db;
                rs_rise  = lcd_rs;
                e_width  = 1;
                rise_cyc = cyc;
                unstable = (lcd_rw !== 1'b0);
            end else if (lcd_e === 1'b1) begin
                e_width++;
                if (lcd_db !== db_rise || lcd_rs !== rs_rise) unstable = 1'b1;
            end else if (e_prev) begin
                checks++;
                if (e_width != T_EHIGH) begin
                    errors++;
                    $display("FAIL e_width: got %0d expected %0d", e_width, T_EHIGH);
                end
                checks++;
                if (unstable) begin
                    errors++;
                    $display("FAIL e_bus_stable: db/rs changed or rw high during pulse (got 1 expected 0)");
                end
                pq.push_back('{db_rise, rs_rise, rise_cyc});
            end
            e_prev = (lcd_e === 1'b1);
        end
    end

    task automatic test_reset();
        @(negedge clk);
        checks++;
        if (lcd_e !== 1'b0 || lcd_rs !== 1'b0 || lcd_db !== 4'h0 || req_ready !== 1'b0 ||
            init_done !== 1'b0 || sf_e !== 1'b1 || lcd_rw !== 1'b0) begin
            errors++;
            $display("FAIL reset_values: got e=%b rs=%b db=%h rdy=%b done=%b sf_e=%b rw=%b expected 0 0 0 0 0 1 0",
                     lcd_e, lcd_rs, lcd_db, req_ready, init_done, sf_e, lcd_rw);
        end
    endtask

    // Release reset and check the whole init sequence
    task automatic test_init();
        int n;
        int c0;
        logic [3:0] exp_db [4];
        exp_db = '{4'h3, 4'h3, 4'h3, 4'h2};
        @(negedge clk);
        pq.delete();
        rst = 1'b0;
        c0 = cyc;
        #1;
        checks++;
        if (lcd_e !== 1'b0 || sf_e !== 1'b1) begin
            errors++;
            $display("FAIL release_outputs: got e=%b sf_e=%b expected 0 1", lcd_e, sf_e);
        end
        n = 0;
        while (init_done !== 1'b1 && n < 1000) begin
            @(posedge clk);
            #1;
            n++;
        end
        checks++;
        if (n != 204) begin
            errors++;
            $display("FAIL init_done_latency: got %0d expected 204", n);
        end
        checks++;
        if (req_ready !== 1'b1) begin
            errors++;
            $display("FAIL ready_with_init_done: got %b expected 1", req_ready);
        end
        checks++;
        if (pq.size() != 4) begin
            errors++;
            $display("FAIL init_pulse_count: got %0d expected 4", pq.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (pq[i].db !== exp_db[i] || pq[i].rs !== 1'b0) begin
                    errors++;
                    $display("FAIL init_nibble%0d: got rs=%b db=%h expected rs=0 db=%h",
                             i, pq[i].rs, pq[i].db, exp_db[i]);
                end
            end
            checks++;
            if (pq[0].rise - c0 != 102) begin
                errors++;
                $display("FAIL first_e_rise: got %0d expected 102", pq[0].rise - c0);
            end
        end
    endtask

    // Send one byte and return cycles from transfer edge until req_ready is back
    task automatic send_byte(input logic rs, input logic [7:0] data, output int lat);
        int n;
        n = 0;
        @(negedge clk);
        while (req_ready !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        req_valid = 1'b1;
        req_rs    = rs;
        req_data  = data;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_data  = 8'hxx;
        lat = 0;
        while (req_ready !== 1'b1 && lat < 200) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic test_char();
        int lat;
        pq.delete();
        send_byte(1'b1, 8'h41, lat);
        checks++;
        if (lat != 25) begin
            errors++;
            $display("FAIL char_latency: got %0d expected 25", lat);
        end
        checks++;
        if (pq.size() != 2) begin
            errors++;
            $display("FAIL char_pulse_count: got %0d expected 2", pq.size());
        end else begin
            checks++;
            if ({pq[0].rs, pq[0].db} !== 5'h14 || {pq[1].rs, pq[1].db} !== 5'h11) begin
                errors++;
                $display("FAIL char_nibbles: got %b_%h %b_%h expected 1_4 1_1",
                         pq[0].rs, pq[0].db, pq[1].rs, pq[1].db);
            end
            checks++;
            if (pq[1].rise - pq[0].rise != 9) begin
                errors++;
                $display("FAIL char_nibble_spacing: got %0d expected 9", pq[1].rise - pq[0].rise);
            end
        end
    endtask

    task automatic test_clear();
        int lat;
        pq.delete();
        send_byte(1'b0, 8'h01, lat);
        checks++;
        if (lat != 45) begin
            errors++;
            $display("FAIL clear_latency: got %0d expected 45", lat);
        end
        checks++;
        if (pq.size() != 2) begin
            errors++;
            $display("FAIL clear_pulse_count: got %0d expected 2", pq.size());
        end else begin
            checks++;
            if ({pq[0].rs, pq[0].db} !== 5'h00 || {pq[1].rs, pq[1].db} !== 5'h01) begin
                errors++;
                $display("FAIL clear_nibbles: got %b_%h %b_%h expected 0_0 0_1",
                         pq[0].rs, pq[0].db, pq[1].rs, pq[1].db);
            end
        end
    endtask

    // Valid held high with data changing every cycle: accepts land every 26 cycles
    task automatic test_back_to_back();
        int n;
        logic [3:0] exp_db [6];
        exp_db = '{4'h2, 4'h0, 4'h3, 4'hA, 4'h5, 4'h4};
        pq.delete();
        for (int k = 0; k <= 78; k++) begin
            @(negedge clk);
            if (k < 78) begin
                req_valid = 1'b1;
                req_rs    = 1'b1;
                req_data  = 8'h20 + 8'(k);
            end else begin
                req_valid = 1'b0;
            end
        end
        n = 0;
        while (req_ready !== 1'b1 && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        checks++;
        if (pq.size() != 6) begin
            errors++;
            $display("FAIL b2b_pulse_count: got %0d expected 6", pq.size());
        end else begin
            for (int i = 0; i < 6; i++) begin
                checks++;
                if (pq[i].db !== exp_db[i] || pq[i].rs !== 1'b1) begin
                    errors++;
                    $display("FAIL b2b_nibble%0d: got rs=%b db=%h expected rs=1 db=%h",
                             i, pq[i].rs, pq[i].db, exp_db[i]);
                end
            end
        end
    endtask

    // Reset asserted while E is high, then a full init replay
    task automatic test_reset_mid();
        int n;
        @(negedge clk);
        req_valid = 1'b1;
        req_rs    = 1'b1;
        req_data  = 8'h41;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        n = 0;
        while (lcd_e !== 1'b1 && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        checks++;
        if (lcd_e !== 1'b1) begin
            errors++;
            $display("FAIL mid_e_reached: got %b expected 1", lcd_e);
        end
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (lcd_e !== 1'b0 || req_ready !== 1'b0 || init_done !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: got e=%b rdy=%b done=%b expected 0 0 0",
                     lcd_e, req_ready, init_done);
        end
        repeat (3) @(negedge clk);
        test_init();
    endtask

    initial begin
        test_reset();
        test_init();
        test_char();
        test_clear();
        test_back_to_back();
        test_reset_mid();
        repeat (5) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
